// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program image loader.
// Pure declarations; no timing or flow-control behaviour of its own.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_CHECK,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Packs accepted bytes little-endian into one instruction word.
// Byte lands in the register on the accepting edge; no backpressure of its own.
module word_assembler
    import program_loader_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_load_byte,
    input  logic                         i_clear,
    input  logic [BYTE_W-1:0]            i_byte,
    output logic [WORD_BYTES*BYTE_W-1:0] o_word,
    output logic                         o_last_byte
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0]             r_byte_idx;
    logic [WORD_BYTES*BYTE_W-1:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_idx <= '0;
            r_word     <= '0;
        end else if (i_clear) begin
            r_byte_idx <= '0;
        end else if (i_load_byte) begin
            r_word[{r_byte_idx, 3'b000} +: BYTE_W] <= i_byte;
            r_byte_idx                             <= r_byte_idx + 1'b1;
        end
    end

    assign o_word      = r_word;
    assign o_last_byte = (r_byte_idx == IDX_W'(WORD_BYTES - 1));

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed image from a byte link into program memory, holding the CPU meanwhile.
// One write strobe the cycle after a word's 4th byte; byte_valid gaps stall indefinitely.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam int IDX_W = $clog2(MEMORY_DEPTH) + 1;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [HDR_BYTES*8-1:0]    r_len;
    logic [IDX_W-1:0]          r_word_idx;
    logic [IDX_W-1:0]          w_word_idx_inc;
    logic [DATA_WIDTH-1:0]     r_waddr_hold;
    logic [DATA_WIDTH-1:0]     r_wdata_hold;
    logic [DATA_WIDTH-1:0]     w_cur_addr;
    logic [DATA_WIDTH-1:0]     w_word;
    logic                      w_load_byte;
    logic                      w_clear;
    logic                      w_last_byte;

    assign w_load_byte    = (r_state == ST_COLLECT) && byte_valid;
    assign w_clear        = (r_state == ST_CHECK) || (r_state == ST_WRITE);
    assign w_word_idx_inc = r_word_idx + 1'b1;
    assign w_cur_addr     = BASE_ADDRESS + (DATA_WIDTH'(r_word_idx) << 2);

    word_assembler u_word_assembler (
        .clk         (clk),
        .reset       (reset),
        .i_load_byte (w_load_byte),
        .i_clear     (w_clear),
        .i_byte      (byte_in),
        .o_word      (w_word),
        .o_last_byte (w_last_byte)
    );

    always_comb begin
        w_state_next = r_state;
        byte_ready   = 1'b0;
        WriteEnable  = 1'b0;
        cpu_hold     = 1'b1;
        done         = 1'b0;
        error        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                cpu_hold = 1'b0;
                if (start) w_state_next = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                byte_ready = 1'b1;
                if (byte_valid) w_state_next = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                byte_ready = 1'b1;
                if (byte_valid) w_state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (r_len == '0)
                    w_state_next = ST_DONE;
                else if (32'(r_len) > 32'(MEMORY_DEPTH))
                    w_state_next = ST_ERROR;
                else
                    w_state_next = ST_COLLECT;
            end
            ST_COLLECT: begin
                byte_ready = 1'b1;
                if (byte_valid && w_last_byte) w_state_next = ST_WRITE;
            end
            ST_WRITE: begin
                WriteEnable = 1'b1;
                if (32'(w_word_idx_inc) == 32'(r_len))
                    w_state_next = ST_DONE;
                else
                    w_state_next = ST_COLLECT;
            end
            ST_DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
                if (start) w_state_next = ST_LEN_LO;
            end
            ST_ERROR: begin
                error = 1'b1;
                if (start) w_state_next = ST_LEN_LO;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_waddr_hold <= BASE_ADDRESS;
            r_wdata_hold <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_LEN_LO: if (byte_valid) r_len[7:0]  <= byte_in;
                ST_LEN_HI: if (byte_valid) r_len[15:8] <= byte_in;
                ST_CHECK:  r_word_idx <= '0;
                ST_WRITE: begin
                    r_word_idx   <= w_word_idx_inc;
                    r_waddr_hold <= w_cur_addr;
                    r_wdata_hold <= w_word;
                end
                default: ;
            endcase
        end
    end

    // Live values during the strobe, last-written values everywhere else.
    assign WriteAddress = (r_state == ST_WRITE) ? w_cur_addr : r_waddr_hold;
    assign WriteData    = (r_state == ST_WRITE) ? w_word     : r_wdata_hold;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    localparam int          DEPTH = 32;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_xfer = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_lat[$];

    program_loader #(
        .MEMORY_DEPTH (DEPTH),
        .DATA_WIDTH   (32),
        .BASE_ADDRESS (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset && WriteEnable) begin
            got_addr.push_back(WriteAddress);
            got_data.push_back(WriteData);
            got_lat.push_back(cyc - last_xfer);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left on a falling edge; byte_ready sampled there decides the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        bit sent = 1'b0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        if (with_start) start = 1'b1;
        for (int k = 0; k < 200 && !sent; k++) begin
            if (byte_ready) begin
                last_xfer = cyc;
                sent      = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
        end
        byte_valid = 1'b0;
        if (!sent) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_load(input bq_t img, input int maxgap, input int start_at);
        int          n;
        bit          exp_err;
        logic [31:0] exp_data[$];
        int          waited;
        int          m;
        n       = int'({img[1], img[0]});
        exp_err = (n > DEPTH);
        if (!exp_err)
            for (int i = 0; i < n; i++)
                exp_data.push_back({img[2+4*i+3], img[2+4*i+2], img[2+4*i+1], img[2+4*i]});
        got_addr.delete();
        got_data.delete();
        got_lat.delete();

        pulse_start();
        chk("start_hold", 32'(cpu_hold), 32'd1);
        chk("start_rdy", 32'(byte_ready), 32'd1);
        chk("start_flags", 32'({done, error}), 32'd0);

        for (int j = 0; j < img.size(); j++)
            send_byte(img[j], $urandom_range(0, maxgap), (j == start_at));

        waited = 0;
        while (!(done || error) && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("end_latency", 32'(waited), 32'd1);
        chk("end_done", 32'(done), 32'(!exp_err));
        chk("end_error", 32'(error), 32'(exp_err));
        chk("end_hold", 32'(cpu_hold), 32'(exp_err));
        chk("end_rdy", 32'(byte_ready), 32'd0);
        chk("n_writes", 32'(got_data.size()), 32'(exp_data.size()));
        m = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("addr[%0d]", i), got_addr[i], BASE + 32'(4 * i));
            chk($sformatf("data[%0d]", i), got_data[i], exp_data[i]);
            chk($sformatf("lat[%0d]", i), 32'(got_lat[i]), 32'd1);
        end
        if (exp_data.size() > 0) begin
            chk("held_addr", WriteAddress, BASE + 32'(4 * (exp_data.size() - 1)));
            chk("held_data", WriteData, exp_data[$]);
        end
    endtask

    function automatic bq_t make_image(input int n);
        bq_t q;
        q.push_back(8'(n));
        q.push_back(8'(n >> 8));
        if (n <= DEPTH)
            for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},   32'(byte_ready), 32'd0);
        chk({tag, "_we"},    32'(WriteEnable), 32'd0);
        chk({tag, "_addr"},  WriteAddress, BASE);
        chk({tag, "_data"},  WriteData, 32'd0);
        chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    initial begin
        bq_t img;
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h08, 8'h00, 8'h10, 8'h00};
        run_load(img, 0, -1);
        chk("basic_w0", (got_data.size() > 0) ? got_data[0] : 32'h0, 32'h2000_0013);
        chk("basic_w1", (got_data.size() > 1) ? got_data[1] : 32'h0, 32'h0010_0008);

        img = {8'h00, 8'h00};
        run_load(img, 2, -1);

        img = {8'h21, 8'h00};
        run_load(img, 0, -1);
        img = make_image(3);
        run_load(img, 1, -1);

        img = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(img, 5, -1);
        chk("bp_word", (got_data.size() > 0) ? got_data[0] : 32'h0, 32'hDEAD_BEEF);

        img = make_image(2);
        run_load(img, 1, 4);

        img = make_image(DEPTH);
        run_load(img, 1, -1);

        for (int t = 0; t < 6; t++) begin
            if ($urandom_range(0, 3) == 0)
                img = make_image($urandom_range(DEPTH + 1, 65535));
            else
                img = make_image($urandom_range(1, 8));
            run_load(img, 3, ($urandom_range(0, 1) == 1) ? 5 : -1);
        end

        img = make_image(3);
        got_addr.delete();
        got_data.delete();
        got_lat.delete();
        pulse_start();
        for (int j = 0; j < 8; j++) send_byte(img[j], $urandom_range(0, 2), 1'b0);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        chk("midreset_writes", 32'(got_data.size()), 32'd1);
        chk("midreset_w0", (got_data.size() > 0) ? got_data[0] : 32'h0,
            {img[5], img[4], img[3], img[2]});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        img = make_image(4);
        run_load(img, 2, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart of the instruction ROM: streams a program image in from a byte source and writes it word-by-word into the instruction memory's write port.
- Holds the CPU in reset while loading and signals completion.
- Sits between the host byte link (UART receiver or test harness) and the writable program memory.

Parameters:
- MEMORY_DEPTH, 32, number of 32-bit words in the target instruction memory.
- DATA_WIDTH, 32, width of the instruction word and byte address; must be 32.
- BASE_ADDRESS, 32'h0000_0000, byte address of the first written word; must be word-aligned.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- byte_in  input  8  incoming image byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- WriteEnable  output  1  one-cycle write strobe to program memory.
- WriteAddress  output  DATA_WIDTH  byte address of the word being written (BASE_ADDRESS + 4*index).
- WriteData  output  DATA_WIDTH  assembled instruction word.
- cpu_hold  output  1  high from start until DONE; keeps the CPU in reset.
- done  output  1  level; load completed successfully.
- error  output  1  level; header word count exceeded MEMORY_DEPTH.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; byte_ready=0, WriteEnable=0, WriteAddress=BASE_ADDRESS, WriteData=0, cpu_hold=0, done=0, error=0; all internal counters cleared.
- Image format: 2-byte word count N (low byte first), then N words of 4 bytes each, little-endian (first byte goes to bits [7:0]).
- States and byte_ready:
  - IDLE: byte_ready=0. start -> LEN_LO, cpu_hold=1.
  - LEN_LO: byte_ready=1. On a transfer, latch N[7:0] -> LEN_HI.
  - LEN_HI: byte_ready=1. On a transfer, latch N[15:8] -> CHECK.
  - CHECK: byte_ready=0, one cycle.
    - N==0 -> DONE.
    - N>MEMORY_DEPTH -> ERROR.
    - Otherwise -> COLLECT with word_idx=0, byte_idx=0.
  - COLLECT: byte_ready=1. Each transfer places byte_in at bits [8*byte_idx+7 : 8*byte_idx] and increments byte_idx. The transfer with byte_idx==3 -> WRITE.
  - WRITE: byte_ready=0. WriteEnable=1 for exactly this cycle; WriteAddress = BASE_ADDRESS + {word_idx,2'b00}; WriteData = assembled word. Next cycle: word_idx+1; if word_idx+1==N -> DONE, else -> COLLECT, byte_idx=0.
  - DONE: done=1, cpu_hold=0, byte_ready=0. start -> LEN_LO; done clears and cpu_hold sets.
  - ERROR: error=1, cpu_hold stays 1, no writes. start -> LEN_LO and clears error.
- Latency: WriteEnable asserts in the cycle after the 4th byte of a word is accepted.
- Back-pressure: gaps in byte_valid stall the FSM indefinitely; no timeout.
- start outside IDLE/DONE/ERROR is ignored.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- WriteAddress and WriteData hold their last values outside WRITE.
- Reset mid-load abandons the load immediately; a partial word is never written.
- word_idx width: $clog2(MEMORY_DEPTH)+1. Addresses never exceed BASE_ADDRESS + 4*(MEMORY_DEPTH-1).

Decomposition:
- Shared package: state encoding constants (IDLE, LEN_LO, LEN_HI, CHECK, COLLECT, WRITE, DONE, ERROR); the WORD_BYTES=4 constant; the header length constant HDR_BYTES=2.
- One sub-module, word_assembler, is natural: a byte_idx counter plus a shift/insert register, with inputs load_byte and clear, and outputs word and last_byte.

Test Plan:
- Basic load: start; stream 02 00, 13 00 00 20, 08 00 10 00 -> two WriteEnable pulses: addr 0x0 data 0x20000013, then addr 0x4 data 0x00100008; done=1, cpu_hold=0.
- Zero count: start; stream 00 00 -> no WriteEnable; done asserts 2 cycles after the 2nd byte.
- Overflow: start; stream 21 00 (N=33, MEMORY_DEPTH=32) -> error=1, cpu_hold=1, no writes, byte_ready=0. A subsequent start clears error.
- Back-pressure: N=1; byte_valid toggles every other cycle, with random 0-5 cycle gaps -> exactly one write, data 0xDEADBEEF from bytes EF BE AD DE.
- Reset mid-load: N=3; assert reset after 6 data bytes -> all outputs at reset values in the same cycle; only one write occurred.
- Ignored start: pulse start during COLLECT -> state, counters and outputs unaffected; the load completes normally.
